// File: rtl/status_led_ctrl.sv
// Board status-LED engine: per-LED runtime mode/source select, a shared heartbeat
// counter and per-LED activity pulse stretchers, configured over a local-bus port.
module status_led_ctrl #(
    parameter int unsigned NLED         = 4,
    parameter int unsigned NSRC         = 8,
    parameter int unsigned HB_BITS      = 28,
    parameter int unsigned STRETCH_BITS = 22,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned RST_MODE     = 2,
    localparam int unsigned SEL_W       = $clog2(NSRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  src,
    input  logic             cfg_valid,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [SEL_W+2:0] cfg_wdata,
    output logic [SEL_W+2:0] cfg_rdata,
    output logic [NLED-1:0]  led
);

    localparam logic [2:0] ModeOff    = 3'd0;
    localparam logic [2:0] ModeOn     = 3'd1;
    localparam logic [2:0] ModeLevel  = 3'd2;
    localparam logic [2:0] ModeInvert = 3'd3;
    localparam logic [2:0] ModeHb     = 3'd4;
    localparam logic [2:0] ModeBlink  = 3'd5;
    localparam logic [2:0] ModeAct    = 3'd6;

    typedef enum logic [1:0] {StIdle, StOn, StGap} act_state_e;

    logic [NSRC-1:0]         s, s_d_q, s_d_d, rise;
    logic [HB_BITS-1:0]      hb_cnt_q, hb_cnt_d;
    logic [SEL_W+2:0]        rdata_q, rdata_d;
    logic [NLED-1:0]         led_q, led_d;
    logic [NLED-1:0]         pend_q, pend_d;
    logic [NLED-1:0]         x_v, r_v, wr_hit;
    logic [2:0]              mode_q [NLED];
    logic [2:0]              mode_d [NLED];
    logic [SEL_W-1:0]        sel_q  [NLED];
    logic [SEL_W-1:0]        sel_d  [NLED];
    logic [STRETCH_BITS-1:0] cnt_q  [NLED];
    logic [STRETCH_BITS-1:0] cnt_d  [NLED];
    act_state_e              st_q   [NLED];
    act_state_e              st_d   [NLED];

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = src;
    end else begin : g_sync
        logic [NSRC-1:0] sync_q [SYNC_STAGES];
        logic [NSRC-1:0] sync_d [SYNC_STAGES];

        always_comb begin
            sync_d[0] = src;
            for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
        end

        always_ff @(posedge clk) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                if (rst) sync_q[k] <= '0;
                else     sync_q[k] <= sync_d[k];
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    assign s_d_d = s;
    assign rise  = s & ~s_d_q;

    // Selects beyond the implemented sources read as 0.
    always_comb begin
        x_v    = '0;
        r_v    = '0;
        wr_hit = '0;
        for (int i = 0; i < NLED; i++) begin
            if (32'(sel_q[i]) < NSRC) begin
                x_v[i] = s[sel_q[i]];
                r_v[i] = rise[sel_q[i]];
            end
            wr_hit[i] = cfg_valid & cfg_we & (cfg_addr == 4'(i));
        end
    end

    always_comb begin
        hb_cnt_d = hb_cnt_q + 1'b1;
        rdata_d  = rdata_q;
        if (cfg_valid && !cfg_we) begin
            rdata_d = '0;
            for (int i = 0; i < NLED; i++) begin
                if (cfg_addr == 4'(i)) rdata_d = {sel_q[i], mode_q[i]};
            end
        end

        led_d  = '0;
        pend_d = pend_q;
        for (int i = 0; i < NLED; i++) begin
            mode_d[i] = mode_q[i];
            sel_d[i]  = sel_q[i];
            st_d[i]   = st_q[i];
            cnt_d[i]  = cnt_q[i];

            if (mode_q[i] == ModeAct) begin
                case (st_q[i])
                    StIdle: begin
                        if (r_v[i]) begin
                            st_d[i]  = StOn;
                            cnt_d[i] = '0;
                        end
                    end
                    StOn: begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                        if (&cnt_q[i]) begin
                            st_d[i]  = StGap;
                            cnt_d[i] = '0;
                        end
                    end
                    StGap: begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                        if (r_v[i]) pend_d[i] = 1'b1;
                        if (&cnt_q[i]) begin
                            st_d[i]   = (pend_q[i] || r_v[i]) ? StOn : StIdle;
                            cnt_d[i]  = '0;
                            pend_d[i] = 1'b0;
                        end
                    end
                    default: st_d[i] = StIdle;
                endcase
            end

            // A config write restarts the stretcher from a clean IDLE.
            if (wr_hit[i]) begin
                {sel_d[i], mode_d[i]} = cfg_wdata;
                st_d[i]   = StIdle;
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
            end

            case (mode_q[i])
                ModeOff:    led_d[i] = 1'b0;
                ModeOn:     led_d[i] = 1'b1;
                ModeLevel:  led_d[i] = x_v[i];
                ModeInvert: led_d[i] = ~x_v[i];
                ModeHb:     led_d[i] = hb_cnt_q[HB_BITS-1];
                ModeBlink:  led_d[i] = x_v[i] & hb_cnt_q[HB_BITS-1];
                ModeAct:    led_d[i] = (st_q[i] == StOn);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d_q    <= '0;
            hb_cnt_q <= '0;
            rdata_q  <= '0;
            led_q    <= '0;
            pend_q   <= '0;
            for (int i = 0; i < NLED; i++) begin
                mode_q[i] <= 3'(RST_MODE);
                sel_q[i]  <= SEL_W'(i % NSRC);
                cnt_q[i]  <= '0;
                st_q[i]   <= StIdle;
            end
        end else begin
            s_d_q    <= s_d_d;
            hb_cnt_q <= hb_cnt_d;
            rdata_q  <= rdata_d;
            led_q    <= led_d;
            pend_q   <= pend_d;
            for (int i = 0; i < NLED; i++) begin
                mode_q[i] <= mode_d[i];
                sel_q[i]  <= sel_d[i];
                cnt_q[i]  <= cnt_d[i];
                st_q[i]   <= st_d[i];
            end
        end
    end

    assign cfg_rdata = rdata_q;
    assign led       = led_q;

endmodule

// File: tb/tb_status_led_ctrl.sv
// Scoreboard bench for status_led_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against led / cfg_rdata.
module tb_status_led_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] src;
    logic       cfg_valid;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [5:0] cfg_wdata;
    logic [5:0] cfg_rdata;
    logic [3:0] led;

    status_led_ctrl #(
        .NLED(4), .NSRC(8), .HB_BITS(4), .STRETCH_BITS(3), .SYNC_STAGES(2), .RST_MODE(2)
    ) dut (
        .clk(clk), .rst(rst), .src(src), .cfg_valid(cfg_valid), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .led(led)
    );

    typedef struct {
        int         at;
        bit         kind;   // 0 = led, 1 = cfg_rdata
        logic [7:0] mask;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   r0    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t       it;
        logic [7:0] act;
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            it    = sbq.pop_front();
            total = total + 1;
            act   = it.kind ? {2'b00, cfg_rdata} : {4'h0, led};
            if (it.at != cyc) begin
                bad = bad + 1;
                $display("FAIL %s: due at cycle %0d, seen at %0d", it.name, it.at, cyc);
            end else if ((act & it.mask) !== it.val) begin
                bad = bad + 1;
                $display("FAIL %s @cyc %0d: got %h want %h (mask %h)",
                         it.name, cyc, act & it.mask, it.val, it.mask);
            end
        end
    end

    task automatic push_exp(input int at, input bit kind, input logic [7:0] mask,
                            input logic [7:0] val, input string name);
        exp_t it;
        int   idx;
        it.at = at; it.kind = kind; it.mask = mask; it.val = val; it.name = name;
        idx = sbq.size();
        while (idx > 0 && sbq[idx-1].at > at) idx--;
        sbq.insert(idx, it);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [2:0] sel, input logic [2:0] mode);
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = {sel, mode};
        step(1);
        cfg_valid = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_rd(input logic [3:0] a, input logic [5:0] want, input string name);
        cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        push_exp(cyc + 1, 1'b1, 8'h3f, {2'b00, want}, name);
        step(1);
        cfg_valid = 1'b0;
    endtask

    // Heartbeat bit as seen on an HB-mode led after edge e, given last reset edge r0.
    function automatic logic hb_at(input int e);
        return ((e - 1 - r0) % 16) >= 8;
    endfunction

    initial begin
        int t0;
        rst = 1'b1; src = 8'h00; cfg_valid = 1'b0; cfg_we = 1'b0;
        cfg_addr = 4'h0; cfg_wdata = 6'h00;

        // Reset state
        push_exp(2, 1'b0, 8'h0f, 8'h00, "reset_led");
        push_exp(2, 1'b1, 8'h3f, 8'h00, "reset_rdata");
        step(3);
        rst = 1'b0;
        r0  = cyc;

        // LEVEL with default selects, including latency boundary
        t0 = cyc;
        src = 8'h05;
        push_exp(t0 + 2, 1'b0, 8'h0f, 8'h00, "level_latency");
        push_exp(t0 + 3, 1'b0, 8'h0f, 8'h05, "level_05");
        step(4);
        cfg_rd(4'd2, {3'd2, 3'd2}, "rd_addr2_reset");

        // Heartbeat on LED0
        cfg_wr(4'd0, 3'd0, 3'd4);
        t0 = cyc;
        for (int e = t0 + 1; e <= t0 + 16; e++)
            push_exp(e, 1'b0, 8'h01, {7'd0, hb_at(e)}, "hb_led0");
        push_exp(t0 + 1, 1'b0, 8'h04, 8'h04, "hb_led2_level");
        step(17);

        // Out-of-range write and read
        cfg_wr(4'd9, 3'd5, 3'd1);
        push_exp(cyc + 1, 1'b0, 8'h0e, 8'h04, "addr9_led");
        cfg_rd(4'd0, {3'd0, 3'd4}, "rd_addr0_hb");
        cfg_rd(4'd1, {3'd1, 3'd2}, "rd_addr1_after9");
        cfg_rd(4'd3, {3'd3, 3'd2}, "rd_addr3_after9");
        cfg_rd(4'd9, 6'd0, "rd_addr9");

        // ACT single pulse on LED1 from src[3]
        cfg_wr(4'd1, 3'd3, 3'd6);
        push_exp(cyc + 1, 1'b0, 8'h02, 8'h00, "act_idle");
        step(2);
        t0 = cyc;
        for (int e = t0 + 2; e <= t0 + 14; e++)
            push_exp(e, 1'b0, 8'h02, (e >= t0 + 4 && e <= t0 + 11) ? 8'h02 : 8'h00,
                     "act_single");
        src = 8'h0d; step(1); src = 8'h05;
        step(21);

        // Continuous traffic: src[3] toggling every 2 cycles -> 8 on / 8 off
        t0 = cyc;
        for (int e = t0 + 2; e <= t0 + 44; e++)
            push_exp(e, 1'b0, 8'h02,
                     (e >= t0 + 4 && ((e - t0 - 4) % 16) < 8) ? 8'h02 : 8'h00, "act_toggle");
        for (int k = 0; k < 23; k++) begin
            src = (k % 2 == 0) ? 8'h0d : 8'h05;
            step(2);
        end
        src = 8'h05;
        step(30);

        // Rise only during GAP -> second pulse right after GAP
        t0 = cyc;
        for (int e = t0 + 2; e <= t0 + 30; e++)
            push_exp(e, 1'b0, 8'h02,
                     ((e >= t0 + 4 && e <= t0 + 11) || (e >= t0 + 20 && e <= t0 + 27))
                     ? 8'h02 : 8'h00, "act_gap_rise");
        src = 8'h0d; step(1); src = 8'h05;
        step(11);
        src = 8'h0d; step(1); src = 8'h05;
        step(25);

        // Reset in the middle of an ON phase
        t0 = cyc;
        src = 8'h0d; step(1); src = 8'h05;
        push_exp(t0 + 6, 1'b0, 8'h02, 8'h02, "pre_rst_on");
        push_exp(t0 + 7, 1'b0, 8'h0f, 8'h00, "rst_mid_led");
        push_exp(t0 + 7, 1'b1, 8'h3f, 8'h00, "rst_mid_rdata");
        push_exp(t0 + 8, 1'b0, 8'h0f, 8'h00, "post_rst_led_a");
        push_exp(t0 + 9, 1'b0, 8'h0f, 8'h00, "post_rst_led_b");
        push_exp(t0 + 10, 1'b0, 8'h0f, 8'h05, "post_rst_level");
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        r0  = cyc;
        cfg_rd(4'd1, {3'd1, 3'd2}, "rd_addr1_post_rst");
        step(3);

        // BLINK, reserved mode, INVERT on LED3 from src[7]
        src = 8'h85;
        step(4);
        cfg_wr(4'd3, 3'd7, 3'd5);
        t0 = cyc;
        for (int e = t0 + 1; e <= t0 + 16; e++)
            push_exp(e, 1'b0, 8'h08, {4'd0, hb_at(e), 3'd0}, "blink_led3");
        step(17);
        cfg_wr(4'd3, 3'd7, 3'd7);
        t0 = cyc;
        for (int e = t0 + 1; e <= t0 + 16; e++)
            push_exp(e, 1'b0, 8'h08, 8'h00, "mode7_off");
        step(17);
        cfg_wr(4'd3, 3'd7, 3'd3);
        push_exp(cyc + 1, 1'b0, 8'h08, 8'h00, "invert_src1");
        step(2);
        t0 = cyc;
        src = 8'h05;
        push_exp(t0 + 2, 1'b0, 8'h08, 8'h00, "invert_latency");
        push_exp(t0 + 3, 1'b0, 8'h08, 8'h08, "invert_src0");
        step(5);

        for (int k = 0; k < 100 && sbq.size() > 0; k++) step(1);
        if (sbq.size() > 0) begin
            $display("FAIL scoreboard: %0d expectations never checked", sbq.size());
            total = total + sbq.size();
            bad   = bad + sbq.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
